// File: rtl/brq_pkg.sv
// Shared constants for the instruction-memory responder.
// Holds the stall-LFSR seed and tap mask plus the LATENCY upper bound.
package brq_pkg;

   localparam int unsigned LAT_MAX    = 8;
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;
   // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS  = 16'h002D;
   localparam int unsigned BEAT_W     = 34;

endpackage

// File: rtl/brq_imem_resp_pipe.sv
// Fixed-length response delay line, LATENCY registered stages.
// Ports: clk_i, rst_i (async, active high), d_i beat in, q_o beat out.
module brq_imem_resp_pipe
   import brq_pkg::*;
#(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned WIDTH   = BEAT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [LATENCY];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[LATENCY-1];

endmodule

// File: rtl/brq_imem_responder.sv
// Instruction-memory responder: fixed-latency, in-order fetch replies.
// Ports: clk_i, rst_i; instr_req_i/addr_i -> gnt_o; rvalid/rdata/err_o;
// load_we/addr/wdata_i backdoor write; outstanding_o in-flight count.
// Optional BRQ_IMEM_STALL_EN: LFSR-driven pseudo-random grant stalls.
module brq_imem_responder
   import brq_pkg::*;
#(
   parameter int unsigned MEM_WORDS       = 1024,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] BASE_ADDR       = 32'h0,
   localparam int unsigned AW             = $clog2(MEM_WORDS),
   localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          instr_req_i,
   input  logic [31:0]   instr_addr_i,
   output logic          instr_gnt_o,
   output logic          instr_rvalid_o,
   output logic [31:0]   instr_rdata_o,
   output logic          instr_err_o,
   input  logic          load_we_i,
   input  logic [AW-1:0] load_addr_i,
   input  logic [31:0]   load_wdata_i,
   output logic [CW-1:0] outstanding_o
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

   logic [31:0]       mem_q [MEM_WORDS];
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [31:0]       offset;
   logic [AW-1:0]     idx;
   logic              in_range;
   logic              stall;
   logic              room;
   logic [BEAT_W-1:0] beat_d, beat_q;
   logic              unused_lsb;

   // Subtraction wraps addresses below BASE_ADDR to large offsets,
   // so a single upper-bits-zero test covers both ends of the window.
   assign offset     = instr_addr_i - BASE_ADDR;
   assign in_range   = (offset >> (AW + 2)) == 32'h0;
   assign idx        = offset[AW+1:2];
   assign unused_lsb = ^offset[1:0];

`ifdef BRQ_IMEM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   assign stall  = lfsr_q[1:0] == 2'b00;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign stall = 1'b0;
`endif

   // A retiring beat frees its slot in the same cycle.
   assign room        = (cnt_q < MAX_C) || instr_rvalid_o;
   assign instr_gnt_o = instr_req_i && !rst_i && room && !stall;

   // Write is on the edge, so a same-cycle grant sees the old word.
   always_ff @(posedge clk_i) begin
      if (load_we_i) mem_q[load_addr_i] <= load_wdata_i;
   end

   always_comb begin
      beat_d = '0;
      if (instr_gnt_o) begin
         beat_d[33] = 1'b1;
         beat_d[32] = !in_range;
         if (in_range) beat_d[31:0] = mem_q[idx];
      end
   end

   brq_imem_resp_pipe #(
      .LATENCY (LATENCY),
      .WIDTH   (BEAT_W)
   ) u_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (beat_d),
      .q_o   (beat_q)
   );

   assign instr_rvalid_o = beat_q[33];
   assign instr_err_o    = beat_q[33] & beat_q[32];
   assign instr_rdata_o  = beat_q[33] ? beat_q[31:0] : 32'h0;

   always_comb begin
      cnt_d = cnt_q;
      case ({instr_gnt_o, instr_rvalid_o})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign outstanding_o = cnt_q;

   a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
      cnt_q <= MAX_C);
   a_cnt_min: assert property (@(posedge clk_i) disable iff (rst_i)
      !(instr_rvalid_o && !instr_gnt_o && cnt_q == '0));

endmodule

// File: tb/tb_brq_imem_responder.sv
// Scoreboard bench for brq_imem_responder with a cycle-level reference model.
// Honours BRQ_IMEM_STALL_EN in the model when the macro is defined.
module tb_brq_imem_responder;

   localparam int unsigned MEM_WORDS = 1024;
   localparam int unsigned LAT       = 3;
   localparam int unsigned MAXO      = 2;
   localparam logic [31:0] BASE      = 32'h0000_0100;
   localparam int unsigned AW        = $clog2(MEM_WORDS);
   localparam int unsigned CW        = $clog2(MAXO + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic [31:0]   addr;
   logic          gnt;
   logic          rvalid;
   logic [31:0]   rdata;
   logic          err;
   logic          we;
   logic [AW-1:0] ladr;
   logic [31:0]   wdat;
   logic [CW-1:0] outst;

   brq_imem_responder #(
      .MEM_WORDS       (MEM_WORDS),
      .LATENCY         (LAT),
      .MAX_OUTSTANDING (MAXO),
      .BASE_ADDR       (BASE)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .instr_req_i    (req),
      .instr_addr_i   (addr),
      .instr_gnt_o    (gnt),
      .instr_rvalid_o (rvalid),
      .instr_rdata_o  (rdata),
      .instr_err_o    (err),
      .load_we_i      (we),
      .load_addr_i    (ladr),
      .load_wdata_i   (wdat),
      .outstanding_o  (outst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem_m [MEM_WORDS];
   logic [15:0] lfsr_m = 16'hACE1;
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, a, e);
      end
   endtask

   task automatic flag(input string n);
      checks++;
      errors++;
      $display("FAIL %s @cyc %0d: got event, expected none", n, cyc);
   endtask

   // Reference model: a grant is allowed while fewer than MAXO beats are
   // in flight, or when one is due this cycle; each reply lands LAT
   // cycles after its grant.
   always @(negedge clk) begin
      logic        retire, exp_g, stl, fb;
      logic [31:0] off;
      exp_t        e;
      cyc++;
      if (rst) begin
         chk("rst_gnt", 32'(gnt), 0);
         chk("rst_rvalid", 32'(rvalid), 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_err", 32'(err), 0);
         chk("rst_outst", 32'(outst), 0);
         sb.delete();
         lfsr_m = 16'hACE1;
      end else begin
         retire = sb.size() > 0 && sb[0].due == cyc;
`ifdef BRQ_IMEM_STALL_EN
         stl = lfsr_m[1:0] == 2'b00;
`else
         stl = 1'b0;
`endif
         exp_g = req && !stl && (sb.size() < MAXO || retire);
         chk("outstanding", 32'(outst), 32'(sb.size()));
         chk("gnt", 32'(gnt), 32'(exp_g));
         if (rvalid) begin
            if (sb.size() == 0) flag("spurious_rvalid");
            else begin
               e = sb.pop_front();
               chk("rdata", rdata, e.d);
               chk("err", 32'(err), 32'(e.e));
               chk("latency", 32'(cyc), 32'(e.due));
            end
         end else begin
            chk("idle_rdata", rdata, 0);
            chk("idle_err", 32'(err), 0);
            if (retire) begin
               chk("missing_rvalid", 32'(rvalid), 1);
               void'(sb.pop_front());
            end
         end
         if (exp_g) begin
            off = addr - BASE;
            if (off >= 32'(4 * MEM_WORDS)) begin
               e.d = 32'h0;
               e.e = 1'b1;
            end else begin
               e.d = mem_m[off / 4];
               e.e = 1'b0;
            end
            e.due = cyc + LAT;
            sb.push_back(e);
         end
         fb     = lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5];
         lfsr_m = {fb, lfsr_m[15:1]};
      end
      if (we) mem_m[ladr] = wdat;
   end

   task automatic drive(input logic r, input logic [31:0] a,
                        input logic w, input logic [AW-1:0] la,
                        input logic [31:0] wd);
      req  = r;
      addr = a;
      we   = w;
      ladr = la;
      wdat = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 32'h0, 1'b0, '0, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      rst = 1'b1;
      repeat (3) drive(1'b1, BASE, 1'b0, '0, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < MEM_WORDS; i++)
         drive(1'b0, 32'h0, 1'b1, AW'(i), $urandom);
      drive(1'b0, 32'h0, 1'b1, AW'(3), 32'hDEADBEEF);
      drive(1'b0, 32'h0, 1'b1, AW'(5), 32'h0);

      drive(1'b1, BASE + 32'hC, 1'b0, '0, 32'h0);
      idle(LAT + 1);
      drive(1'b1, BASE + 32'h1000, 1'b0, '0, 32'h0);
      idle(LAT + 1);
      drive(1'b1, BASE - 32'h4, 1'b0, '0, 32'h0);
      idle(LAT + 1);

      drive(1'b1, BASE + 32'h16, 1'b1, AW'(5), 32'h1);
      idle(LAT + 1);
      drive(1'b1, BASE + 32'h14, 1'b0, '0, 32'h0);
      idle(LAT + 1);

      for (int i = 0; i < 6; i++)
         drive(1'b1, BASE + 32'(4 * i), 1'b0, '0, 32'h0);
      idle(LAT + 1);

      drive(1'b1, BASE + 32'h20, 1'b0, '0, 32'h0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(LAT + 3);

      for (int i = 0; i < 2000; i++) begin
         k = $urandom_range(0, 9);
         if (k == 0)      a = BASE + 32'(4 * MEM_WORDS) + $urandom_range(0, 64);
         else if (k == 1) a = BASE - 32'($urandom_range(1, 64));
         else             a = BASE + ($urandom & 32'(4 * MEM_WORDS - 1));
         drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 4) == 0,
               AW'($urandom), $urandom);
      end

      k = 0;
      while (sb.size() > 0 && k < 20) begin
         idle(1);
         k++;
      end
      chk("drain", 32'(sb.size()), 0);
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/brq_imem_responder.md
BRQ_IMEM_RESPONDER -- requirements
Module: brq_imem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 1, cycles from grant to rvalid (legal 1..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered requests (legal 1..LATENCY+1).
REQ-003 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words (power of two).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-005 SHALL have port clk_i, input, 1, sole clock; one clock domain.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports instr_req_i, input, 1 and instr_addr_i, input, 32 for the fetch request and its byte address.
REQ-008 SHALL have port instr_gnt_o, output, 1, request accepted this cycle.
REQ-009 SHALL have ports instr_rvalid_o, output, 1; instr_rdata_o, output, 32; and instr_err_o, output, 1 for the response.
REQ-010 SHALL have ports load_we_i, input, 1; load_addr_i, input, log2(MEM_WORDS); and load_wdata_i, input, 32 for the backdoor word write.
REQ-011 SHALL have port outstanding_o, output, log2(MAX_OUTSTANDING+1), current outstanding count.

Function
REQ-012 SHALL assert instr_gnt_o combinationally as instr_req_i AND (outstanding < MAX_OUTSTANDING), or with outstanding == MAX_OUTSTANDING when a response retires in the same cycle.
REQ-013 SHALL ignore instr_addr_i[1:0]; fetches are word-aligned.
REQ-014 SHALL read the memory word at grant time; index = (instr_addr_i - BASE_ADDR)[log2(MEM_WORDS)+1:2].
REQ-015 SHALL flag a granted address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) as an error and return err=1 with rdata=32'h0.
REQ-016 SHALL carry each granted beat {valid, rdata, err} through a LATENCY-stage shift pipeline; instr_rvalid_o equals the last stage's valid bit.
REQ-017 SHALL return responses strictly in grant order, exactly LATENCY cycles after the grant edge, with no backpressure.
REQ-018 SHALL drive instr_rdata_o and instr_err_o to 0 whenever instr_rvalid_o is 0.
REQ-019 SHALL update the outstanding counter as +1 on grant, -1 on rvalid, unchanged when both occur in one cycle.
REQ-020 SHALL never let the counter exceed MAX_OUTSTANDING or wrap below 0 (assertion).
REQ-021 SHALL apply load_we_i writes on the clock edge; a grant reading the same word in the same cycle returns the old data.
REQ-022 SHALL sustain back-to-back grants every cycle when MAX_OUTSTANDING >= LATENCY.

Reset
REQ-023 SHALL clear, on rst_i, all pipeline valid bits, the counter and the stall LFSR; while rst_i is high, instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, outstanding_o=0.
REQ-024 SHALL drop responses in flight when reset asserts mid-operation; none are emitted after release.
REQ-025 SHALL not reset memory contents.

Configuration
REQ-026 SHALL, with BRQ_IMEM_STALL_EN defined, gate instr_gnt_o with a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) that advances every cycle; grant is blocked when LFSR[1:0]==2'b00.
REQ-027 SHALL, without BRQ_IMEM_STALL_EN defined, contain no LFSR logic and follow REQ-012 exactly.

Structure
REQ-028 SHALL place the constants LFSR seed, tap mask and LATENCY maximum in shared package brq_pkg.
REQ-029 SHALL implement the response delay line as sub-module brq_imem_resp_pipe, parameterised by LATENCY and width 34.

Verification
REQ-030 SHALL cover: LATENCY=1, word 3=32'hDEADBEEF, request addr 0xC -> gnt same cycle, rvalid next cycle with rdata DEADBEEF, err=0.
REQ-031 SHALL cover: LATENCY=3, MAX_OUTSTANDING=2, req held for 6 cycles -> 2 grants, then gnt low until first rvalid, and outstanding_o never exceeds 2.
REQ-032 SHALL cover: MEM_WORDS=1024, addr 0x1000 -> rvalid with err=1 and rdata=0.
REQ-033 SHALL cover: load write word 5=32'h1 in the same cycle as a grant of addr 0x14 (old value 32'h0) -> response 32'h0; the next fetch returns 32'h1.
REQ-034 SHALL cover: rst_i pulsed one cycle after a grant with LATENCY=2 -> no rvalid ever appears and outstanding_o=0.
REQ-035 SHALL cover: BRQ_IMEM_STALL_EN defined, req held 64 cycles -> grants match the LFSR reference model, and responses arrive in order with the correct data.
